// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/response bundle between a requester and alu_seq
interface alu_seq_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       opcode;
   logic [WIDTH-1:0] op1;
   logic [WIDTH-1:0] op2;
   logic             out_valid;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             carry;
   logic             zero;
   logic             err;

   modport master (
      output in_valid, opcode, op1, op2,
      input  in_ready, out_valid, result, result_hi, carry, zero, err
   );

   modport slave (
      input  in_valid, opcode, op1, op2,
      output in_ready, out_valid, result, result_hi, carry, zero, err
   );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - single-cycle ALU with a multi-cycle shift-add multiplier
module alu_seq #(
   parameter int WIDTH  = 8,
   parameter bit MUL_EN = 1'b1
) (
   input logic       clk,
   input logic       reset,
   alu_seq_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic {
      IDLE,
      MULT
   } state_t;

   state_t state;
   state_t state_next;

   logic             accept;
   logic             mul_op;
   logic             mul_last;

   logic             out_valid_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] result_hi_q;
   logic             carry_q;
   logic             zero_q;
   logic             err_q;

   logic [CW-1:0]    step_cnt;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH:0]   pp_sum;
   logic [2*WIDTH-1:0] prod_next;

   logic [WIDTH:0]   a_ext;
   logic [WIDTH:0]   b_ext;
   logic [WIDTH:0]   sum_w;
   logic [WIDTH-1:0] alu_res;
   logic             alu_carry;
   logic             alu_err;

   assign bus.in_ready  = (state == IDLE) && !reset;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.result_hi = result_hi_q;
   assign bus.carry     = carry_q;
   assign bus.zero      = zero_q;
   assign bus.err       = err_q;

   assign mul_op = MUL_EN && (bus.opcode == 4'd13);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      mul_last   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.in_valid && !reset) begin
               accept = 1'b1;
               if (mul_op) begin
                  state_next = MULT;
               end
            end
         end
         MULT: begin
            if (step_cnt == CW'(WIDTH - 1)) begin
               mul_last   = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      a_ext     = {1'b0, bus.op1};
      b_ext     = {1'b0, bus.op2};
      sum_w     = '0;
      alu_res   = '0;
      alu_carry = carry_q;
      alu_err   = 1'b0;
      case (bus.opcode)
         4'd0:  alu_res = bus.op1 & bus.op2;
         4'd1:  alu_res = bus.op1 | bus.op2;
         4'd2:  alu_res = bus.op1 ^ bus.op2;
         4'd3:  alu_res = WIDTH'(bus.op1 >  bus.op2);
         4'd4:  alu_res = WIDTH'(bus.op1 >= bus.op2);
         4'd5:  alu_res = WIDTH'(bus.op1 == bus.op2);
         4'd6:  alu_res = WIDTH'(bus.op1 <= bus.op2);
         4'd7:  alu_res = WIDTH'(bus.op1 <  bus.op2);
         4'd8: begin
            sum_w     = a_ext + b_ext;
            alu_res   = sum_w[WIDTH-1:0];
            alu_carry = sum_w[WIDTH];
         end
         4'd9: begin
            sum_w     = a_ext - b_ext;
            alu_res   = sum_w[WIDTH-1:0];
            alu_carry = sum_w[WIDTH];
         end
         4'd10: alu_res = bus.op1;
         4'd11: begin
            sum_w     = a_ext + b_ext + {{WIDTH{1'b0}}, carry_q};
            alu_res   = sum_w[WIDTH-1:0];
            alu_carry = sum_w[WIDTH];
         end
         4'd12: begin
            sum_w     = a_ext - b_ext - {{WIDTH{1'b0}}, carry_q};
            alu_res   = sum_w[WIDTH-1:0];
            alu_carry = sum_w[WIDTH];
         end
         4'd14: begin
            alu_res   = {bus.op1[WIDTH-2:0], 1'b0};
            alu_carry = bus.op1[WIDTH-1];
         end
         4'd15: begin
            alu_res   = {1'b0, bus.op1[WIDTH-1:1]};
            alu_carry = bus.op1[0];
         end
         // Only opcode 13 reaches here; when MUL_EN=1 it takes the multiplier path instead.
         default: alu_err = 1'b1;
      endcase
   end

   // Multiplier lives in the low half of prod; each step adds into the high half and shifts right.
   always_comb begin
      pp_sum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
      prod_next = {pp_sum, prod[WIDTH-1:1]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         result_hi_q <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b1;
         err_q       <= 1'b0;
         step_cnt    <= '0;
         prod        <= '0;
         mcand       <= '0;
      end else begin
         out_valid_q <= 1'b0;
         if (accept && mul_op) begin
            prod     <= {{WIDTH{1'b0}}, bus.op2};
            mcand    <= bus.op1;
            step_cnt <= '0;
         end else if (accept) begin
            out_valid_q <= 1'b1;
            result_q    <= alu_res;
            result_hi_q <= '0;
            carry_q     <= alu_carry;
            zero_q      <= (alu_res == '0);
            err_q       <= alu_err;
         end
         if (state == MULT) begin
            prod     <= prod_next;
            step_cnt <= step_cnt + CW'(1);
            if (mul_last) begin
               out_valid_q <= 1'b1;
               result_q    <= prod_next[WIDTH-1:0];
               result_hi_q <= prod_next[2*WIDTH-1:WIDTH];
               carry_q     <= |prod_next[2*WIDTH-1:WIDTH];
               zero_q      <= (prod_next[WIDTH-1:0] == '0);
               err_q       <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed and randomized model check of alu_seq
module tb_alu_seq;
   localparam int W = 8;
   localparam longint unsigned MASK = (64'd1 << W) - 64'd1;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic [3:0]   opcode = 4'd0;
   logic [W-1:0] op1 = '0;
   logic [W-1:0] op2 = '0;

   int passes = 0;
   int total  = 0;
   int cyc    = 0;
   bit model_ok = 1'b0;

   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(W)) bus1 ();
   alu_seq_if #(.WIDTH(W)) bus0 ();

   assign bus1.in_valid = in_valid;
   assign bus1.opcode   = opcode;
   assign bus1.op1      = op1;
   assign bus1.op2      = op2;
   assign bus0.in_valid = in_valid;
   assign bus0.opcode   = opcode;
   assign bus0.op1      = op1;
   assign bus0.op2      = op2;

   alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut  (.clk(clk), .reset(reset), .bus(bus1));
   alu_seq #(.WIDTH(W), .MUL_EN(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

   typedef struct {
      int              busy;
      longint unsigned res;
      longint unsigned hi;
      longint unsigned plo;
      longint unsigned phi;
      bit              ov;
      bit              c;
      bit              z;
      bit              e;
   } mst_t;

   mst_t m1;
   mst_t m0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end else begin
         passes++;
      end
   endfunction

   // Architectural view: what the outputs must be after one more clock edge.
   function automatic mst_t step(mst_t s, bit mul_en);
      longint unsigned a;
      longint unsigned b;
      longint unsigned r;
      longint unsigned cin;
      bit newc;
      if (reset) begin
         s.busy = 0; s.res = 0; s.hi = 0; s.plo = 0; s.phi = 0;
         s.ov = 1'b0; s.c = 1'b0; s.z = 1'b1; s.e = 1'b0;
         return s;
      end
      s.ov = 1'b0;
      if (s.busy > 0) begin
         s.busy--;
         if (s.busy == 0) begin
            s.ov = 1'b1; s.res = s.plo; s.hi = s.phi;
            s.c = (s.phi != 0); s.z = (s.plo == 0); s.e = 1'b0;
         end
         return s;
      end
      if (!in_valid) return s;
      a   = 64'(op1);
      b   = 64'(op2);
      cin = 64'(s.c);
      if (opcode == 4'd13 && mul_en) begin
         s.busy = W;
         s.plo  = (a * b) & MASK;
         s.phi  = (a * b) >> W;
         return s;
      end
      r = 0;
      s.ov = 1'b1; s.hi = 0; s.e = 1'b0;
      case (opcode)
         4'd0:  r = a & b;
         4'd1:  r = a | b;
         4'd2:  r = a ^ b;
         4'd3:  r = (a >  b) ? 64'd1 : 64'd0;
         4'd4:  r = (a >= b) ? 64'd1 : 64'd0;
         4'd5:  r = (a == b) ? 64'd1 : 64'd0;
         4'd6:  r = (a <= b) ? 64'd1 : 64'd0;
         4'd7:  r = (a <  b) ? 64'd1 : 64'd0;
         4'd8:  begin r = a + b; s.c = (r > MASK); end
         4'd9:  begin s.c = (a < b); r = a - b; end
         4'd10: r = a;
         4'd11: begin r = a + b + cin; s.c = (r > MASK); end
         4'd12: begin newc = (a < b + cin); r = a - b - cin; s.c = newc; end
         4'd13: begin r = 0; s.e = 1'b1; end
         4'd14: begin s.c = a[W-1]; r = a << 1; end
         default: begin s.c = a[0]; r = a >> 1; end
      endcase
      s.res = r & MASK;
      s.z   = (s.res == 0);
      return s;
   endfunction

   task automatic compare_one(string tag, mst_t s, logic rdy, logic ov, logic [W-1:0] r,
                              logic [W-1:0] hi, logic c, logic z, logic e);
      check({tag, ".in_ready"},  64'(rdy), 64'((s.busy == 0) && !reset));
      check({tag, ".out_valid"}, 64'(ov),  64'(s.ov));
      check({tag, ".result"},    64'(r),   s.res);
      check({tag, ".result_hi"}, 64'(hi),  s.hi);
      check({tag, ".carry"},     64'(c),   64'(s.c));
      check({tag, ".zero"},      64'(z),   64'(s.z));
      check({tag, ".err"},       64'(e),   64'(s.e));
   endtask

   always @(posedge clk) begin
      cyc++;
      m1 = step(m1, 1'b1);
      m0 = step(m0, 1'b0);
      if (reset) model_ok = 1'b1;
   end

   always @(negedge clk) begin
      if (model_ok) begin
         compare_one("mul1", m1, bus1.in_ready, bus1.out_valid, bus1.result, bus1.result_hi,
                     bus1.carry, bus1.zero, bus1.err);
         compare_one("mul0", m0, bus0.in_ready, bus0.out_valid, bus0.result, bus0.result_hi,
                     bus0.carry, bus0.zero, bus0.err);
      end
   end

   task automatic drive(bit v, logic [3:0] opc, logic [W-1:0] a, logic [W-1:0] b);
      @(posedge clk);
      #2;
      in_valid = v;
      opcode   = opc;
      op1      = a;
      op2      = b;
   endtask

   task automatic expect1(string name, logic [W-1:0] r, logic c, logic z);
      check({name, ".ov"}, 64'(bus1.out_valid), 64'd1);
      check({name, ".res"}, 64'(bus1.result), 64'(r));
      check({name, ".c"}, 64'(bus1.carry), 64'(c));
      check({name, ".z"}, 64'(bus1.zero), 64'(z));
   endtask

   initial begin
      int acc;
      int lat;
      int lowcnt;
      int ovcnt;

      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      check("rst.result", 64'(bus1.result), 64'd0);
      check("rst.zero", 64'(bus1.zero), 64'd1);
      check("rst.ready", 64'(bus1.in_ready), 64'd1);

      drive(1'b1, 4'd8, 8'hF0, 8'h20);
      drive(1'b1, 4'd11, 8'h01, 8'h01);
      @(negedge clk); expect1("add", 8'h10, 1'b1, 1'b0);
      drive(1'b0, 4'd0, 8'h00, 8'h00);
      @(negedge clk); expect1("adc", 8'h03, 1'b0, 1'b0);

      drive(1'b1, 4'd9, 8'h05, 8'h06);
      drive(1'b1, 4'd12, 8'h10, 8'h00);
      @(negedge clk); expect1("sub", 8'hFF, 1'b1, 1'b0);
      drive(1'b1, 4'd7, 8'h03, 8'h07);
      @(negedge clk); expect1("sbb", 8'h0F, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 8'h00, 8'h00);
      @(negedge clk); expect1("lt", 8'h01, 1'b0, 1'b0);

      drive(1'b1, 4'd2, 8'hA5, 8'h0F);
      drive(1'b1, 4'd14, 8'h81, 8'h55);
      @(negedge clk); expect1("xor", 8'hAA, 1'b0, 1'b0);
      drive(1'b1, 4'd15, 8'h01, 8'hFF);
      @(negedge clk); expect1("shl", 8'h02, 1'b1, 1'b0);
      drive(1'b0, 4'd0, 8'h00, 8'h00);
      @(negedge clk); expect1("shr", 8'h00, 1'b1, 1'b1);

      drive(1'b1, 4'd13, 8'h05, 8'h03);
      drive(1'b1, 4'd0, 8'h0F, 8'h3C);
      @(negedge clk);
      check("unk.res", 64'(bus0.result), 64'd0);
      check("unk.err", 64'(bus0.err), 64'd1);
      drive(1'b0, 4'd0, 8'h00, 8'h00);
      @(negedge clk);
      check("and.res", 64'(bus0.result), 64'h0C);
      check("and.err", 64'(bus0.err), 64'd0);
      repeat (10) drive(1'b0, 4'd0, 8'h00, 8'h00);

      drive(1'b1, 4'd13, 8'hFF, 8'hFF);
      drive(1'b1, 4'd8, 8'h01, 8'h01);
      acc = cyc; lat = -1; lowcnt = 0;
      for (int k = 0; k < 20 && lat < 0; k++) begin
         @(negedge clk);
         if (!bus1.in_ready) lowcnt++;
         if (bus1.out_valid) lat = cyc - acc;
         if (k == 3) begin
            @(posedge clk);
            #2 in_valid = 1'b0;
         end
      end
      check("mul.latency", 64'(lat), 64'(W));
      check("mul.ready_low", 64'(lowcnt), 64'(W));
      check("mul.res", 64'(bus1.result), 64'h01);
      check("mul.hi", 64'(bus1.result_hi), 64'hFE);
      check("mul.c", 64'(bus1.carry), 64'd1);
      @(negedge clk);
      check("mul.no_queue", 64'(bus1.out_valid), 64'd0);

      drive(1'b1, 4'd13, 8'hFF, 8'hFF);
      drive(1'b0, 4'd0, 8'h00, 8'h00);
      drive(1'b0, 4'd0, 8'h00, 8'h00);
      drive(1'b0, 4'd0, 8'h00, 8'h00);
      @(posedge clk); #2 reset = 1'b1;
      @(negedge clk);
      check("abort.ready_in_reset", 64'(bus1.in_ready), 64'd0);
      @(posedge clk); #2 reset = 1'b0;
      @(negedge clk);
      check("abort.ready", 64'(bus1.in_ready), 64'd1);
      check("abort.res", 64'(bus1.result), 64'd0);
      check("abort.hi", 64'(bus1.result_hi), 64'd0);
      check("abort.zero", 64'(bus1.zero), 64'd1);
      check("abort.carry", 64'(bus1.carry), 64'd0);
      ovcnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus1.out_valid) ovcnt++;
      end
      check("abort.no_ov", 64'(ovcnt), 64'd0);

      for (int n = 0; n < 3000; n++) begin
         @(posedge clk);
         #2;
         reset    = ($urandom_range(0, 199) == 0);
         in_valid = ($urandom_range(0, 3) != 0);
         opcode   = 4'($urandom);
         case ($urandom_range(0, 3))
            0: op1 = '0;
            1: op1 = '1;
            default: op1 = W'($urandom);
         endcase
         case ($urandom_range(0, 3))
            0: op2 = '0;
            1: op2 = '1;
            default: op2 = W'($urandom);
         endcase
      end
      @(posedge clk);
      #2 reset = 1'b0; in_valid = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 4..32.
REQ-002 Parameter: MUL_EN, default 1, 1 = MUL opcode implemented, 0 = MUL treated as unknown opcode.
REQ-003 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  operation request strobe.
REQ-006 Port: in_ready  output  1  block can accept a request this cycle.
REQ-007 Port: opcode  input  4  operation select, encoding per REQ-013.
REQ-008 Port: op1  input  WIDTH  first operand.
REQ-009 Port: op2  input  WIDTH  second operand.
REQ-010 Port: out_valid  output  1  one-cycle pulse, result/flags updated this cycle.
REQ-011 Port: result  output  WIDTH  operation result, held between out_valid pulses.
REQ-012 Port: result_hi  output  WIDTH  upper product half for MUL, 0 for all other ops; carry  output  1  carry/borrow flag; zero  output  1  result==0; err  output  1  unknown opcode.

Function
REQ-013 Opcodes: 0 AND, 1 OR, 2 XOR, 3 GT, 4 GE, 5 EQ, 6 LE, 7 LT, 8 ADD, 9 SUB, 10 LD, 11 ADC, 12 SBB, 13 MUL, 14 SHL, 15 SHR.
REQ-014 Request accepted on rising edge when in_valid && in_ready; operands and opcode captured at acceptance; later input changes have no effect on that operation.
REQ-015 FSM states: IDLE, MULT; IDLE->MULT on accepted MUL (MUL_EN=1); MULT->IDLE after WIDTH iterations; all other accepted ops stay IDLE.
REQ-016 in_ready = 1 in IDLE, 0 in MULT and during the cycle reset is asserted.
REQ-017 Non-MUL ops: result, flags and out_valid registered on the acceptance edge; latency 1 cycle; back-to-back requests accepted every cycle.
REQ-018 MUL: unsigned shift-add, one partial-product step per cycle; out_valid asserted WIDTH cycles after acceptance; result = product[WIDTH-1:0], result_hi = product[2*WIDTH-1:WIDTH].
REQ-019 Compare ops (unsigned): result = 1 (zero-extended) if true, else 0.
REQ-020 ADD/SUB: computed at WIDTH+1 bits with zero-extended operands; result = low WIDTH bits; carry = bit WIDTH (SUB: 1 = borrow).
REQ-021 ADC = op1+op2+carry; SBB = op1-op2-carry; carry in is the stored flag value before the operation; carry updated as REQ-020.
REQ-022 SHL/SHR: shift op1 by 1; carry = bit shifted out; vacated bit = 0; op2 ignored.
REQ-023 MUL: carry = 1 if result_hi != 0, else 0.
REQ-024 AND/OR/XOR/compares/LD (result = op1): carry unchanged.
REQ-025 zero updated on every out_valid from the new result (WIDTH bits only; result_hi ignored).
REQ-026 Unknown opcode (13 with MUL_EN=0): result = 0, result_hi = 0, err = 1, carry unchanged, latency 1; err cleared to 0 on next out_valid of a legal op.
REQ-027 No out_valid: result, result_hi, carry, zero, err hold previous values.
REQ-028 in_valid asserted in MULT: ignored (not accepted, not queued).

Reset
REQ-029 reset asserted: next edge forces IDLE, in_ready=1 afterwards, out_valid=0, result=0, result_hi=0, carry=0, zero=1, err=0.
REQ-030 reset has priority over acceptance; reset during MULT aborts the multiply with no out_valid.
REQ-031 in_valid with reset high is not accepted.

Verification
REQ-032 WIDTH=8: ADD 0xF0+0x20 -> 1 cycle later out_valid, result=0x10, carry=1, zero=0; then ADC 0x01+0x01 -> result=0x03, carry=0.
REQ-033 SUB 0x05-0x06 -> result=0xFF, carry=1; SBB 0x10-0x00 -> result=0x0F, carry=0; LT 0x03,0x07 -> result=0x01, carry=0 unchanged.
REQ-034 MUL 0xFF*0xFF -> in_ready low 8 cycles, out_valid 8 cycles after acceptance, result=0x01, result_hi=0xFE, carry=1; in_valid during MULT ignored.
REQ-035 Reset asserted 3 cycles into MUL -> no out_valid, all outputs at REQ-029 values, in_ready=1 following cycle.
REQ-036 MUL_EN=0, opcode 13 -> result=0, err=1; following AND 0x0F,0x3C -> result=0x0C, err=0.
REQ-037 Back-to-back: XOR, SHL 0x81, SHR 0x01 on consecutive cycles -> three consecutive out_valid; results 0xXX, 0x02/carry=1, 0x00/carry=1/zero=1.
